// File: rtl/ntt_layer_scheduler.sv
// ntt_layer_scheduler: sequences the layers of a 256-point NTT/INTT over NUM_BU butterfly units
// Ports: clk_i/rst_i (sync, active-high), start_i/is_NTT_i request a run (sampled in IDLE);
//   busy_o, layer_o, olen_o, beat_o, rd_en_o drive address generation and BRAM reads;
//   wr_en_o/wr_beat_o tag write-back DRAIN cycles later; done_o pulses once per run.
// Option: define NTT_SCHED_PERF_EN to add run_cycles_o[15:0], a per-run busy-cycle counter.
module ntt_layer_scheduler #(
  parameter int NUM_LAYERS   = 7,
  parameter int BF_PER_LAYER = 128,
  parameter int NUM_BU       = 8,
  parameter int RD_LATENCY   = 2,
  parameter int BU_LATENCY   = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       is_NTT_i,
  output logic       busy_o,
  output logic [2:0] layer_o,
  output logic [7:0] olen_o,
  output logic [3:0] beat_o,
  output logic       rd_en_o,
  output logic       wr_en_o,
  output logic [3:0] wr_beat_o,
  output logic       done_o
`ifdef NTT_SCHED_PERF_EN
  ,
  output logic [15:0] run_cycles_o
`endif
);
  localparam int BEATS = BF_PER_LAYER / NUM_BU;
  localparam int DRAIN = RD_LATENCY + BU_LATENCY;
  localparam int CW    = $clog2(DRAIN + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t                  state_q, state_d;
  logic [2:0]              layer_q, layer_d;
  logic [3:0]              beat_q, beat_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    rd_en_q, busy_q, done_q;
  logic [DRAIN-1:0]        wr_sr_q, wr_sr_d;
  logic [DRAIN-1:0][3:0]   wb_sr_q, wb_sr_d;
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_ISSUE;
        layer_d = '0;
        beat_d  = '0;
        mode_d  = is_NTT_i;
      end
      S_ISSUE: if (beat_q == 4'(BEATS - 1)) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end else beat_d = beat_q + 4'd1;
      S_DRAIN: if (cnt_q == CW'(DRAIN - 1)) begin
        if (layer_q == 3'(NUM_LAYERS - 1)) state_d = S_DONE;
        else begin
          state_d = S_ISSUE;
          layer_d = layer_q + 3'd1;
          beat_d  = '0;
        end
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = S_IDLE;
    endcase
  end
  // Write-back tags trail the read strobe by the full read + butterfly latency.
  always_comb begin
    wr_sr_d    = wr_sr_q;
    wb_sr_d    = wb_sr_q;
    wr_sr_d[0] = rd_en_q;
    wb_sr_d[0] = beat_q;
    for (int i = 1; i < DRAIN; i++) begin
      wr_sr_d[i] = wr_sr_q[i-1];
      wb_sr_d[i] = wb_sr_q[i-1];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_sr_q <= '0;
      wb_sr_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      rd_en_q <= state_d == S_ISSUE;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_d == S_DONE;
      wr_sr_q <= wr_sr_d;
      wb_sr_q <= wb_sr_d;
    end
  end
`ifdef NTT_SCHED_PERF_EN
  logic [15:0] run_q, run_d;
  always_comb run_d = (state_q == S_IDLE && start_i) ? '0 : busy_q ? run_q + 16'd1 : run_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) run_q <= '0;
    else run_q <= run_d;
  end
  assign run_cycles_o = run_q;
`endif
  // Mode latched at start keeps olen stable even if is_NTT_i changes mid-run.
  assign olen_o    = mode_q ? 8'(BF_PER_LAYER) >> layer_q : 8'd2 << layer_q;
  assign busy_o    = busy_q;
  assign layer_o   = layer_q;
  assign beat_o    = beat_q;
  assign rd_en_o   = rd_en_q;
  assign wr_en_o   = wr_sr_q[DRAIN-1];
  assign wr_beat_o = wb_sr_q[DRAIN-1];
  assign done_o    = done_q;
endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// tb_ntt_layer_scheduler: directed table-driven checks of the NTT layer scheduler
module tb_ntt_layer_scheduler;
  logic clk = 1'b0;
  logic rst, start, is_ntt;
  logic busy, rd_en, wr_en, done;
  logic [2:0] layer;
  logic [7:0] olen;
  logic [3:0] beat, wr_beat;
`ifdef NTT_SCHED_PERF_EN
  logic [15:0] run_cycles;
  int r_run [400];
`endif
  int checks = 0;
  int failures = 0;
  int r_rd [400], r_beat [400], r_wr [400], r_wbeat [400];
  int r_olen [400], r_layer [400], r_busy [400], r_done [400];

  ntt_layer_scheduler dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .is_NTT_i(is_ntt),
    .busy_o(busy), .layer_o(layer), .olen_o(olen), .beat_o(beat),
    .rd_en_o(rd_en), .wr_en_o(wr_en), .wr_beat_o(wr_beat), .done_o(done)
`ifdef NTT_SCHED_PERF_EN
    , .run_cycles_o(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int prof; int cyc; int rd; int beat; int wr; int wbeat;
    int olen; int layer; int busy; int done;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t v(input int p, c, rd, b, wr, wb, ol, ly, bs, dn);
    vec_t e;
    e.prof = p; e.cyc = c; e.rd = rd; e.beat = b; e.wr = wr; e.wbeat = wb;
    e.olen = ol; e.layer = ly; e.busy = bs; e.done = dn;
    return e;
  endfunction

  // Start at edge 0; r_*[c] holds outputs seen during cycle c (sampled 1 time unit after edge c-1).
  task automatic run(input bit mode, input bit hold, input bit toggle, input int n);
    is_ntt = mode;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      r_rd[c] = int'(rd_en); r_beat[c] = int'(beat); r_wr[c] = int'(wr_en);
      r_wbeat[c] = int'(wr_beat); r_olen[c] = int'(olen); r_layer[c] = int'(layer);
      r_busy[c] = int'(busy); r_done[c] = int'(done);
`ifdef NTT_SCHED_PERF_EN
      r_run[c] = int'(run_cycles);
`endif
      if (toggle && c % 20 == 10) is_ntt = ~is_ntt;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_tbl(input string tag, input int prof);
    foreach (tbl[k]) begin
      vec_t e = tbl[k];
      if (e.prof == prof) begin
        string s = $sformatf("%s c%0d", tag, e.cyc);
        if (e.rd >= 0) chk({s, " rd_en"}, r_rd[e.cyc], e.rd);
        if (e.beat >= 0) chk({s, " beat"}, r_beat[e.cyc], e.beat);
        if (e.wr >= 0) chk({s, " wr_en"}, r_wr[e.cyc], e.wr);
        if (e.wbeat >= 0) chk({s, " wr_beat"}, r_wbeat[e.cyc], e.wbeat);
        if (e.olen >= 0) chk({s, " olen"}, r_olen[e.cyc], e.olen);
        if (e.layer >= 0) chk({s, " layer"}, r_layer[e.cyc], e.layer);
        if (e.busy >= 0) chk({s, " busy"}, r_busy[e.cyc], e.busy);
        if (e.done >= 0) chk({s, " done"}, r_done[e.cyc], e.done);
      end
    end
  endtask

  task automatic check_sums(input string tag, input int n);
    int nrd = 0, nwr = 0, nd = 0, nb = 0, dpos = -1;
    for (int c = 1; c <= n; c++) begin
      nrd += r_rd[c]; nwr += r_wr[c]; nd += r_done[c]; nb += r_busy[c];
      if (r_done[c] == 1 && dpos < 0) dpos = c;
    end
    chk({tag, " rd_en count"}, nrd, 112);
    chk({tag, " wr_en count"}, nwr, 112);
    chk({tag, " done count"}, nd, 1);
    chk({tag, " done cycle"}, dpos, 169);
    chk({tag, " busy count"}, nb, 169);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " rd_en"}, int'(rd_en), 0);
    chk({tag, " wr_en"}, int'(wr_en), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " layer"}, int'(layer), 0);
    chk({tag, " beat"}, int'(beat), 0);
    chk({tag, " wr_beat"}, int'(wr_beat), 0);
    chk({tag, " olen"}, int'(olen), 128);
  endtask

  initial begin
    // NTT profile: layer 0 read/write window, layer starts, final drain and done.
    tbl.push_back(v(0,   1, 1,  0, 0, -1, 128, 0, 1, 0));
    tbl.push_back(v(0,   8, 1,  7, 0, -1, 128, 0, 1, 0));
    tbl.push_back(v(0,   9, 1,  8, 1,  0, 128, 0, 1, 0));
    tbl.push_back(v(0,  16, 1, 15, 1,  7, 128, 0, 1, 0));
    tbl.push_back(v(0,  17, 0, -1, 1,  8, 128, 0, 1, 0));
    tbl.push_back(v(0,  24, 0, -1, 1, 15, 128, 0, 1, 0));
    tbl.push_back(v(0,  25, 1,  0, 0, -1,  64, 1, 1, 0));
    tbl.push_back(v(0,  49, 1,  0, 0, -1,  32, 2, 1, 0));
    tbl.push_back(v(0,  73, 1,  0, 0, -1,  16, 3, 1, 0));
    tbl.push_back(v(0,  97, 1,  0, 0, -1,   8, 4, 1, 0));
    tbl.push_back(v(0, 121, 1,  0, 0, -1,   4, 5, 1, 0));
    tbl.push_back(v(0, 145, 1,  0, 0, -1,   2, 6, 1, 0));
    tbl.push_back(v(0, 168, 0, -1, 1, 15,   2, 6, 1, 0));
    tbl.push_back(v(0, 169, 0, -1, 0, -1,  -1, -1, 1, 1));
    tbl.push_back(v(0, 170, 0, -1, 0, -1,  -1, -1, 0, 0));
    // INTT profile: olen grows 2..128, checked at start and end of each layer window.
    tbl.push_back(v(1,   1, 1,  0, 0, -1,   2, 0, 1, 0));
    tbl.push_back(v(1,  24, 0, -1, 1, 15,   2, 0, 1, 0));
    tbl.push_back(v(1,  25, 1,  0, 0, -1,   4, 1, 1, 0));
    tbl.push_back(v(1,  49, 1,  0, 0, -1,   8, 2, 1, 0));
    tbl.push_back(v(1,  72, 0, -1, 1, 15,   8, 2, 1, 0));
    tbl.push_back(v(1,  73, 1,  0, 0, -1,  16, 3, 1, 0));
    tbl.push_back(v(1,  97, 1,  0, 0, -1,  32, 4, 1, 0));
    tbl.push_back(v(1, 121, 1,  0, 0, -1,  64, 5, 1, 0));
    tbl.push_back(v(1, 145, 1,  0, 0, -1, 128, 6, 1, 0));
    tbl.push_back(v(1, 169, 0, -1, 0, -1, 128, 6, 1, 1));
    tbl.push_back(v(1, 170, 0, -1, 0, -1,  -1, -1, 0, 0));

    rst = 1'b1; start = 1'b0; is_ntt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run(1'b1, 1'b0, 1'b0, 175);
    check_tbl("ntt", 0);
    check_sums("ntt", 175);
`ifdef NTT_SCHED_PERF_EN
    chk("perf after done", r_run[170], 169);
    chk("perf held", r_run[175], 169);
`endif

    run(1'b0, 1'b0, 1'b1, 175);
    check_tbl("intt", 1);
    check_sums("intt", 175);

    // start_i held high: the DONE-cycle request is ignored, the next IDLE cycle accepts it.
    run(1'b1, 1'b1, 1'b0, 172);
    start = 1'b0;
    check_tbl("hold", 0);
    chk("hold c171 rd_en", r_rd[171], 1);
    chk("hold c171 beat", r_beat[171], 0);
    chk("hold c171 busy", r_busy[171], 1);
    chk("hold c172 beat", r_beat[172], 1);
    begin
      int waited = 0;
      while (!done && waited < 300) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("hold run2 done seen", int'(done), 1);
      @(posedge clk); #1;
    end

    // Reset in layer 1 ISSUE aborts the run with no trailing write-back.
    run(1'b1, 1'b0, 1'b0, 29);
    chk("pre-rst c30 rd_en", int'(rd_en), 1);
    chk("pre-rst c30 layer", int'(layer), 1);
    chk("pre-rst c30 beat", int'(beat), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("mid-rst");
    rst = 1'b0;
    begin
      int nwr = 0, nrd = 0;
      for (int c = 0; c < 20; c++) begin
        nwr += int'(wr_en);
        nrd += int'(rd_en);
        @(posedge clk); #1;
      end
      chk("post-rst wr_en count", nwr, 0);
      chk("post-rst rd_en count", nrd, 0);
    end
    run(1'b1, 1'b0, 1'b0, 175);
    check_tbl("rerun", 0);
    check_sums("rerun", 175);
`ifdef NTT_SCHED_PERF_EN
    chk("perf cleared on start", r_run[1], 0);
    chk("perf rerun", r_run[172], 169);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
